cpu_state_controller: RTL and testbench
=======================================

// Module: cpu_state_controller
// PURPOSE
//  Multi-cycle sequencer for the rv32i core: drives current_state to alu_controller.
//  Fetches instructions over a req/valid imem handshake and latches the ALU result each state.
//  Performs load/store over a req/valid dmem handshake and issues the register write-back pulse.
//  Selects the next PC and halts on traps.
// PARAMETERS
//  RESET_PC       32'h0000_0000  PC value loaded on reset
//  MEM_TIMEOUT    16             max cycles waiting for imem_valid/dmem_valid before bus-error halt (>=1)
// PORTS
//  clk            in   1   core clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  opcode         in   7   opcode_t, decoded from instr (combinational, external decoder)
//  funct3         in   3   funct3 field of instr
//  alu_result     in   32  ALU output for operands chosen by alu_controller this cycle
//  imem_req       out  1   instruction fetch request
//  imem_addr      out  32  fetch address (= current_pc)
//  imem_rdata     in   32  fetched instruction, valid with imem_valid
//  imem_valid     in   1   fetch completion, single-cycle pulse
//  dmem_req       out  1   data access request
//  dmem_we        out  1   1 = store, 0 = load
//  dmem_addr      out  32  data address (= alu_out_q)
//  dmem_rdata     in   32  load data, valid with dmem_valid
//  dmem_valid     in   1   data access completion, single-cycle pulse
//  current_state  out  3   FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 HALT=5
//  current_pc     out  32  PC of the instruction in flight
//  instr          out  32  latched instruction register
//  reg_we         out  1   register-file write enable, 1-cycle pulse in WRITEBACK
//  wb_data        out  32  register write data
//  halt           out  1   high while in HALT
//  trap_cause     out  2   0 none, 1 bus timeout, 2 misaligned target, 3 ECALL/EBREAK/illegal
//  instret        out  32  retired-instruction counter, wraps 0xFFFF_FFFF -> 0
// BEHAVIOUR
//  Reset: state=FETCH, current_pc=RESET_PC, instr=32'h0000_0013, all other regs/outputs 0.
//  Reset has priority in every state, including mid-handshake; pending req is dropped, late valid ignored.
//  FETCH: imem_req=1, imem_addr=current_pc.
//    On imem_valid: instr<=imem_rdata, pc4_q<=alu_result (PC+4), wait counter cleared, ->DECODE.
//  DECODE: 1 cycle. tgt_q<=alu_result (PC+imm or rs1+imm). ->EXECUTE.
//    tgt_q is written every DECODE and is used only by JAL/JALR/BRANCH.
//  EXECUTE: 1 cycle. alu_out_q<=alu_result.
//    opcode outside the rv32i set ->HALT, cause 3.
//    OP_SYSTEM with funct3==0 ->HALT, cause 3.
//    OP_LOAD/OP_STORE ->MEMORY; all others ->WRITEBACK.
//  MEMORY: dmem_req=1, dmem_we=(opcode==OP_STORE), dmem_addr=alu_out_q.
//    On dmem_valid: ld_q<=dmem_rdata, ->WRITEBACK.
//  Wait counter increments each FETCH/MEMORY cycle without valid.
//    Reaching MEM_TIMEOUT with no valid ->HALT, cause 1.
//    valid on the same edge as the timeout wins (normal progress).
//  Branch taken, from alu_out_q:
//    BEQ: alu_out_q==0.  BNE: alu_out_q!=0.
//    BLT/BLTU: alu_out_q[0]==1.  BGE/BGEU: alu_out_q[0]==0.
//  WRITEBACK, 1 cycle:
//    reg_we=1 for R/I/LOAD/LUI/AUIPC/JAL/JALR; 0 for STORE/BRANCH/FENCE/SYSTEM.
//    wb_data: pc4_q for JAL/JALR, ld_q for LOAD, else alu_out_q.
//    next PC: JAL -> tgt_q; JALR -> {tgt_q[31:1],1'b0}; taken BRANCH -> tgt_q; else pc4_q.
//    Chosen jump/branch target with [1:0]!=0 -> HALT, cause 2; PC unchanged, reg_we still pulses.
//    Otherwise current_pc<=next, instret+=1, ->FETCH.
//  HALT: terminal until rst. All req=0, reg_we=0, halt=1, trap_cause held.
//  req is a level held until valid; dmem_we/addr stable while req=1. No outstanding access survives a state exit.
//  No combinational path from imem_valid/dmem_valid to any output.
// TESTING
//  rst 1 cycle, imem returns 0x00500093 (addi x1,x0,5) after 2 cycles -> states 0,0,0,1,2,4,0; reg_we once; wb_data=5; pc 0->4; instret=1.
//  BEQ x0,x0,+8 at pc 0x10, alu_out_q=0 -> next current_pc=0x18, reg_we=0.
//  JALR at pc 0x20, tgt=0x101 -> pc=0x100, wb_data=0x24; tgt=0x102 -> HALT, cause 2.
//  LW with dmem_valid after 3 cycles, rdata 0xDEADBEEF -> dmem_req high 4 cycles, wb_data=0xDEADBEEF.
//  SW: dmem_we=1 -> reg_we=0.  imem_valid never arrives -> HALT after MEM_TIMEOUT cycles, cause 1.
//  rst asserted mid-MEMORY with dmem_valid next cycle -> FETCH, pc=RESET_PC, valid ignored, instret=0.

Source files
------------

// File: rtl/cpu_state_controller.sv
// Multi-cycle rv32i sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// req/valid memory handshakes, bus-timeout and trap halting.
module cpu_state_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_valid,
  output logic [2:0]  current_state,
  output logic [31:0] current_pc,
  output logic [31:0] instr,
  output logic        reg_we,
  output logic [31:0] wb_data,
  output logic        halt,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_n;
  logic [31:0]   pc4_q, tgt_q, alu_out_q, ld_q;
  logic [CW-1:0] wait_cnt, cnt_n;
  logic [1:0]    trap_q, trap_n;
  logic          commit, legal, wb_en, br_taken, redirect, misalign;
  logic [31:0]   tgt_sel, next_pc;

  always_comb begin
    legal = 1'b0;
    wb_en = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_OP, OP_LUI, OP_JALR, OP_JAL: begin
        legal = 1'b1;
        wb_en = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: ;
    endcase
  end

  // Branch compare was done by the ALU in EXECUTE; only its result is inspected here.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = (alu_out_q == 32'd0);
      3'b001:         br_taken = (alu_out_q != 32'd0);
      3'b100, 3'b110: br_taken = alu_out_q[0];
      3'b101, 3'b111: br_taken = !alu_out_q[0];
      default:        br_taken = 1'b0;
    endcase
  end

  assign redirect = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                    ((opcode == OP_BRANCH) && br_taken);
  assign tgt_sel  = (opcode == OP_JALR) ? {tgt_q[31:1], 1'b0} : tgt_q;
  assign next_pc  = redirect ? tgt_sel : pc4_q;
  assign misalign = redirect && (tgt_sel[1:0] != 2'b00);

  always_comb begin
    state_n = state;
    trap_n  = trap_q;
    cnt_n   = wait_cnt;
    commit  = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_valid) begin
          state_n = S_DECODE;
          cnt_n   = '0;
        end else if (wait_cnt == TO_LAST) begin
          state_n = S_HALT;
          trap_n  = 2'd1;
        end else begin
          cnt_n = wait_cnt + CW'(1);
        end
      end
      S_DECODE: state_n = S_EXECUTE;
      S_EXECUTE: begin
        if (!legal || ((opcode == OP_SYSTEM) && (funct3 == 3'b000))) begin
          state_n = S_HALT;
          trap_n  = 2'd3;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_n = S_MEMORY;
        end else begin
          state_n = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_valid) begin
          state_n = S_WRITEBACK;
          cnt_n   = '0;
        end else if (wait_cnt == TO_LAST) begin
          state_n = S_HALT;
          trap_n  = 2'd1;
        end else begin
          cnt_n = wait_cnt + CW'(1);
        end
      end
      S_WRITEBACK: begin
        if (misalign) begin
          state_n = S_HALT;
          trap_n  = 2'd2;
        end else begin
          commit  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      current_pc <= RESET_PC;
      instr      <= 32'h0000_0013;
      pc4_q      <= '0;
      tgt_q      <= '0;
      alu_out_q  <= '0;
      ld_q       <= '0;
      wait_cnt   <= '0;
      trap_q     <= '0;
      instret    <= '0;
    end else begin
      state    <= state_n;
      trap_q   <= trap_n;
      wait_cnt <= cnt_n;
      if ((state == S_FETCH) && imem_valid) begin
        instr <= imem_rdata;
        pc4_q <= alu_result;
      end
      if (state == S_DECODE)  tgt_q     <= alu_result;
      if (state == S_EXECUTE) alu_out_q <= alu_result;
      if ((state == S_MEMORY) && dmem_valid) ld_q <= dmem_rdata;
      if (commit) begin
        current_pc <= next_pc;
        instret    <= instret + 32'd1;
      end
    end
  end

  // All outputs derive from registered state only; valid inputs never reach them.
  assign current_state = state;
  assign imem_req      = (state == S_FETCH);
  assign imem_addr     = current_pc;
  assign dmem_req      = (state == S_MEMORY);
  assign dmem_we       = (state == S_MEMORY) && (opcode == OP_STORE);
  assign dmem_addr     = alu_out_q;
  assign reg_we        = (state == S_WRITEBACK) && wb_en;
  assign wb_data       = ((opcode == OP_JAL) || (opcode == OP_JALR)) ? pc4_q :
                         (opcode == OP_LOAD) ? ld_q : alu_out_q;
  assign halt          = (state == S_HALT);
  assign trap_cause    = trap_q;
endmodule

// File: tb/tb_cpu_state_controller.sv
// Directed bench for cpu_state_controller: the bench plays decoder, ALU and both memories.
module tb_cpu_state_controller;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic        imem_req, dmem_req, dmem_we, reg_we, halt;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata;
  logic        imem_valid, dmem_valid;
  logic [2:0]  current_state;
  logic [31:0] current_pc, instr, wb_data, instret;
  logic [1:0]  trap_cause;

  logic [31:0] tb_tgt, tb_alu;
  int          vecs = 0, errs = 0;
  int          mreq_cycles;
  logic        mwe, wb_we;
  logic [31:0] maddr, wb_val;
  logic [2:0]  wb_state;

  cpu_state_controller #(.RESET_PC(32'h0), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_result(alu_result),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_valid(dmem_valid), .current_state(current_state), .current_pc(current_pc),
    .instr(instr), .reg_we(reg_we), .wb_data(wb_data), .halt(halt),
    .trap_cause(trap_cause), .instret(instret));

  always #5 clk = ~clk;

  // External decoder and an ALU that returns PC+4 / target / result depending on the phase.
  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign alu_result = (current_state == 3'd0) ? current_pc + 32'd4 :
                      (current_state == 3'd1) ? tb_tgt : tb_alu;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] ins, input int dly);
    for (int i = 0; i < dly; i++) tick();
    imem_rdata = ins; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] tgt, input logic [31:0] alu,
                           input logic [31:0] rdata, input int fdly, input int mdly);
    tb_tgt = tgt; tb_alu = alu;
    do_fetch(ins, fdly);
    tick();
    tick();
    mreq_cycles = 0; mwe = 1'b0; maddr = '0;
    if (current_state == 3'd3) begin
      for (int i = 0; i <= mdly; i++) begin
        mreq_cycles += int'(dmem_req); mwe = dmem_we; maddr = dmem_addr;
        if (i == mdly) begin dmem_rdata = rdata; dmem_valid = 1'b1; end
        tick();
      end
      dmem_valid = 1'b0;
    end
    wb_state = current_state; wb_we = reg_we; wb_val = wb_data;
    if (current_state == 3'd4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_valid = 1'b0; dmem_valid = 1'b0; tb_tgt = '0; tb_alu = '0;
    imem_rdata = '0; dmem_rdata = '0;
    tick(); tick();
    vecs++; if (current_state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d want 0", current_state); end
    vecs++; if (current_pc !== 32'h0) begin errs++; $display("FAIL reset_pc got %h want 0", current_pc); end
    vecs++; if (instr !== 32'h13) begin errs++; $display("FAIL reset_instr got %h want 00000013", instr); end
    vecs++; if ({halt, reg_we, dmem_req, trap_cause} !== 5'b0) begin errs++; $display("FAIL reset_outs got %b want 00000", {halt, reg_we, dmem_req, trap_cause}); end
    vecs++; if (instret !== 32'h0) begin errs++; $display("FAIL reset_instret got %h want 0", instret); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [2:0] st [7];
    logic [2:0] exp_st [7];
    int we_cnt = 0;
    logic [31:0] wbd = '0;
    exp_st = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    tb_alu = 32'd5; imem_rdata = 32'h0050_0093;
    for (int i = 0; i < 7; i++) begin
      st[i] = current_state;
      if (reg_we) begin we_cnt++; wbd = wb_data; end
      imem_valid = (i == 2);
      tick();
    end
    imem_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vecs++; if (st[i] !== exp_st[i]) begin errs++; $display("FAIL addi_state[%0d] got %0d want %0d", i, st[i], exp_st[i]); end
    end
    vecs++; if (we_cnt != 1) begin errs++; $display("FAIL addi_we_count got %0d want 1", we_cnt); end
    vecs++; if (wbd !== 32'd5) begin errs++; $display("FAIL addi_wb_data got %h want 5", wbd); end
    vecs++; if (current_pc !== 32'h4) begin errs++; $display("FAIL addi_pc got %h want 4", current_pc); end
    vecs++; if (instret !== 32'd1) begin errs++; $display("FAIL addi_instret got %0d want 1", instret); end
  endtask

  task automatic test_branch();
    run_instr(32'h0100_006f, 32'h10, 32'h0, 32'h0, 0, 0);  // jal x0 -> 0x10
    vecs++; if (wb_we !== 1'b1 || wb_val !== 32'h8) begin errs++; $display("FAIL jal_wb got we=%b data=%h want we=1 data=8", wb_we, wb_val); end
    vecs++; if (current_pc !== 32'h10) begin errs++; $display("FAIL jal_pc got %h want 10", current_pc); end
    run_instr(32'h0000_0463, 32'h18, 32'h0, 32'h0, 1, 0);  // beq taken
    vecs++; if (wb_we !== 1'b0) begin errs++; $display("FAIL beq_we got %b want 0", wb_we); end
    vecs++; if (current_pc !== 32'h18) begin errs++; $display("FAIL beq_pc got %h want 18", current_pc); end
    run_instr(32'h0000_4463, 32'h20, 32'h0, 32'h0, 0, 0);  // blt not taken
    vecs++; if (current_pc !== 32'h1c) begin errs++; $display("FAIL blt_pc got %h want 1c", current_pc); end
    run_instr(32'h0000_1463, 32'h28, 32'h5, 32'h0, 0, 0);  // bne taken
    vecs++; if (current_pc !== 32'h28) begin errs++; $display("FAIL bne_pc got %h want 28", current_pc); end
    vecs++; if (instret !== 32'd5) begin errs++; $display("FAIL branch_instret got %0d want 5", instret); end
  endtask

  task automatic test_jalr();
    run_instr(32'h0100_006f, 32'h20, 32'h0, 32'h0, 0, 0);
    run_instr(32'h0001_00e7, 32'h101, 32'h0, 32'h0, 0, 0);
    vecs++; if (wb_we !== 1'b1 || wb_val !== 32'h24) begin errs++; $display("FAIL jalr_wb got we=%b data=%h want we=1 data=24", wb_we, wb_val); end
    vecs++; if (current_pc !== 32'h100) begin errs++; $display("FAIL jalr_pc got %h want 100", current_pc); end
    run_instr(32'h0001_00e7, 32'h102, 32'h0, 32'h0, 0, 0);
    vecs++; if (wb_state !== 3'd4 || wb_we !== 1'b1 || wb_val !== 32'h104) begin errs++; $display("FAIL jalr_mis_wb got st=%0d we=%b data=%h want st=4 we=1 data=104", wb_state, wb_we, wb_val); end
    vecs++; if (current_state !== 3'd5 || trap_cause !== 2'd2) begin errs++; $display("FAIL jalr_mis_halt got st=%0d cause=%0d want st=5 cause=2", current_state, trap_cause); end
    vecs++; if (current_pc !== 32'h100 || instret !== 32'd7) begin errs++; $display("FAIL jalr_mis_pc got pc=%h ir=%0d want pc=100 ir=7", current_pc, instret); end
    for (int i = 0; i < 3; i++) begin imem_valid = 1'b1; tick(); end
    imem_valid = 1'b0;
    vecs++; if ({halt, imem_req, reg_we, trap_cause} !== 5'b10010 || current_state !== 3'd5) begin errs++; $display("FAIL halt_hold got h/ireq/we/cause=%b st=%0d want 10010 st=5", {halt, imem_req, reg_we, trap_cause}, current_state); end
  endtask

  task automatic test_load_store();
    do_reset();
    run_instr(32'h0001_2083, 32'h0, 32'h40, 32'hDEAD_BEEF, 0, 3);
    vecs++; if (mreq_cycles != 4) begin errs++; $display("FAIL lw_req_cycles got %0d want 4", mreq_cycles); end
    vecs++; if (mwe !== 1'b0 || maddr !== 32'h40) begin errs++; $display("FAIL lw_bus got we=%b addr=%h want we=0 addr=40", mwe, maddr); end
    vecs++; if (wb_we !== 1'b1 || wb_val !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_wb got we=%b data=%h want we=1 data=deadbeef", wb_we, wb_val); end
    vecs++; if (current_pc !== 32'h4 || instret !== 32'd1) begin errs++; $display("FAIL lw_pc got pc=%h ir=%0d want pc=4 ir=1", current_pc, instret); end
    run_instr(32'h0011_2223, 32'h0, 32'h44, 32'h0, 0, 0);
    vecs++; if (mreq_cycles != 1 || mwe !== 1'b1 || maddr !== 32'h44) begin errs++; $display("FAIL sw_bus got n=%0d we=%b addr=%h want n=1 we=1 addr=44", mreq_cycles, mwe, maddr); end
    vecs++; if (wb_we !== 1'b0) begin errs++; $display("FAIL sw_we got %b want 0", wb_we); end
    vecs++; if (current_pc !== 32'h8 || instret !== 32'd2) begin errs++; $display("FAIL sw_pc got pc=%h ir=%0d want pc=8 ir=2", current_pc, instret); end
  endtask

  task automatic test_ecall();
    run_instr(32'h0000_0073, 32'h0, 32'h0, 32'h0, 0, 0);
    vecs++; if (current_state !== 3'd5 || trap_cause !== 2'd3 || halt !== 1'b1) begin errs++; $display("FAIL ecall got st=%0d cause=%0d halt=%b want st=5 cause=3 halt=1", current_state, trap_cause, halt); end
    vecs++; if (current_pc !== 32'h8 || instret !== 32'd2) begin errs++; $display("FAIL ecall_pc got pc=%h ir=%0d want pc=8 ir=2", current_pc, instret); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO - 1; i++) tick();
    vecs++; if (current_state !== 3'd0) begin errs++; $display("FAIL timeout_early got st=%0d want 0", current_state); end
    tick();
    vecs++; if (current_state !== 3'd5 || trap_cause !== 2'd1 || imem_req !== 1'b0) begin errs++; $display("FAIL timeout got st=%0d cause=%0d req=%b want st=5 cause=1 req=0", current_state, trap_cause, imem_req); end
    do_reset();
    do_fetch(32'h0050_0093, TO - 1);
    vecs++; if (current_state !== 3'd1 || trap_cause !== 2'd0) begin errs++; $display("FAIL timeout_edge_valid got st=%0d cause=%0d want st=1 cause=0", current_state, trap_cause); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(32'h0050_0093, 32'h0, 32'h5, 32'h0, 0, 0);
    tb_alu = 32'h80;
    do_fetch(32'h0001_2083, 0);
    tick(); tick(); tick();
    vecs++; if (current_state !== 3'd3 || dmem_req !== 1'b1 || instret !== 32'd1) begin errs++; $display("FAIL mid_pre got st=%0d req=%b ir=%0d want st=3 req=1 ir=1", current_state, dmem_req, instret); end
    rst = 1'b1; tick(); rst = 1'b0;
    dmem_rdata = 32'h1234_5678; dmem_valid = 1'b1;
    vecs++; if (current_state !== 3'd0 || current_pc !== 32'h0 || instret !== 32'd0 || dmem_req !== 1'b0) begin errs++; $display("FAIL mid_reset got st=%0d pc=%h ir=%0d req=%b want st=0 pc=0 ir=0 req=0", current_state, current_pc, instret, dmem_req); end
    tick();
    dmem_valid = 1'b0;
    vecs++; if (current_state !== 3'd0 || reg_we !== 1'b0 || instr !== 32'h13) begin errs++; $display("FAIL mid_late_valid got st=%0d we=%b instr=%h want st=0 we=0 instr=13", current_state, reg_we, instr); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jalr();
    test_load_store();
    test_ecall();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
